// File: rtl/uart_pkg.sv
// Shared UART timing constants: divisor bounds, standard 100 MHz divisors, default oversample ratio.
package uart_pkg;

    localparam int DIV_MIN          = 2;
    localparam int DIV_9600_100M    = 651;
    localparam int DIV_115200_100M  = 54;
    localparam int OSR_DEFAULT      = 16;

    // A divisor below DIV_MIN would make the stage-1 terminal count underflow.
    function automatic logic div_is_valid(input logic [31:0] div);
        return div >= 32'(DIV_MIN);
    endfunction

endpackage

// File: rtl/prog_mod_cnt.sv
// Modulo counter with enable, synchronous clear and a runtime modulus; wrap flags the terminal count.
module prog_mod_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W:0]   modulus,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   last;

    // Modulus is one bit wider than the count so a modulus of 2**W still fits.
    always_comb begin
        last  = modulus - 1'b1;
        wrap  = ~reset & en & ~clr & ({1'b0, cnt_q} == last);
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Two-stage baud tick generator: clk / divisor -> sample_tick, sample_tick / OSR -> bit_tick,
// with glitch-free divisor updates applied only at a stage-1 wrap or a phase restart.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = DIV_9600_100M,
    parameter int OSR         = OSR_DEFAULT,
    parameter int OSR_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             div_busy,
    output logic             div_err,
    output logic [DIV_W-1:0] div_cur,
    output logic             sample_tick,
    output logic             bit_tick,
    output logic [DIV_W-1:0] q,
    output logic [OSR_W-1:0] os_q
);

    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             wr_ok;
    logic             apply;

    prog_mod_cnt #(.W(DIV_W)) u_stage1 (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (sync_clr),
        .modulus ({1'b0, div_cur_q}),
        .cnt     (q),
        .wrap    (sample_tick)
    );

    prog_mod_cnt #(.W(OSR_W)) u_stage2 (
        .clk     (clk),
        .reset   (reset),
        .en      (sample_tick),
        .clr     (sync_clr),
        .modulus ((OSR_W+1)'(OSR)),
        .cnt     (os_q),
        .wrap    (bit_tick)
    );

    // A valid write in an apply cycle goes straight to div_cur; a rejected one never blocks pending.
    always_comb begin
        wr_ok     = div_wr & div_is_valid(32'(div_in));
        apply     = sample_tick | sync_clr;
        err_d     = div_wr & ~wr_ok;
        pend_d    = wr_ok ? div_in : pend_q;
        div_cur_d = div_cur_q;
        busy_d    = busy_q;
        if (apply) begin
            busy_d = 1'b0;
            if (wr_ok)
                div_cur_d = div_in;
            else if (busy_q)
                div_cur_d = pend_q;
        end else if (wr_ok) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cur_q <= DIV_W'(DIV_DEFAULT);
            pend_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign div_cur  = div_cur_q;
    assign div_busy = busy_q;
    assign div_err  = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen with a small divisor and OSR, against a cycle-level behavioural model.
module tb_baud_tick_gen;

    localparam int DIV_W = 16;
    localparam int DDEF  = 4;
    localparam int OSR   = 4;
    localparam int OSR_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sync_clr = 1'b0;
    logic             div_wr = 1'b0;
    logic [DIV_W-1:0] div_in = '0;
    logic             div_busy, div_err, sample_tick, bit_tick;
    logic [DIV_W-1:0] div_cur, q;
    logic [OSR_W-1:0] os_q;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: elapsed cycles in the current sample period, total samples since
    // the last phase restart, the divisor in force and a queue of writes awaiting an apply point.
    int m_elapsed = 0;
    int m_samples = 0;
    int m_div     = DDEF;
    int m_err     = 0;
    int m_pend[$];

    baud_tick_gen #(
        .DIV_W(DIV_W), .DIV_DEFAULT(DDEF), .OSR(OSR), .OSR_W(OSR_W)
    ) dut (
        .clk(clk), .reset(rst), .en(en), .sync_clr(sync_clr),
        .div_wr(div_wr), .div_in(div_in), .div_busy(div_busy), .div_err(div_err),
        .div_cur(div_cur), .sample_tick(sample_tick), .bit_tick(bit_tick),
        .q(q), .os_q(os_q)
    );

    always #5 clk = ~clk;

    function automatic bit m_tick();
        return !rst && en && !sync_clr && (m_elapsed == m_div - 1);
    endfunction

    function automatic bit m_btick();
        return m_tick() && ((m_samples % OSR) == OSR - 1);
    endfunction

    function automatic logic [37:0] exp_vec();
        return {m_tick(), m_btick(), (m_pend.size() != 0), (m_err != 0),
                16'(m_div), 16'(m_elapsed), 2'(m_samples % OSR)};
    endfunction

    function automatic logic [37:0] obs_vec();
        return {sample_tick, bit_tick, div_busy, div_err, div_cur, q, os_q};
    endfunction

    task automatic model_update();
        bit tick;
        bit ok;
        tick = m_tick();
        ok   = div_wr && (div_in >= 2);
        if (rst) begin
            m_elapsed = 0; m_samples = 0; m_div = DDEF; m_err = 0;
            m_pend.delete();
            return;
        end
        m_err = (div_wr && !ok) ? 1 : 0;
        if (sync_clr) begin
            m_elapsed = 0; m_samples = 0;
        end else if (en) begin
            if (tick) begin
                m_elapsed = 0; m_samples++;
            end else begin
                m_elapsed++;
            end
        end
        if (tick || sync_clr) begin
            if (ok) m_div = int'(div_in);
            else if (m_pend.size() != 0) m_div = m_pend[$];
            m_pend.delete();
        end else if (ok) begin
            m_pend.push_back(int'(div_in));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; sync_clr = 1'b0; div_wr = 1'b0; div_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; div_wr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #1;
        n_tests++;
        if ({sample_tick, bit_tick, div_busy, div_err, div_cur, q, os_q} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 16'(DDEF), 16'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs_vec(),
                     {4'b0, 16'(DDEF), 16'd0, 2'd0});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_free_run();
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            #1;
            n_tests++;
            if (obs_vec() !== exp_vec() || q !== 16'(i % 4) ||
                sample_tick !== ((i % 4) == 3) || bit_tick !== ((i % 16) == 15)) begin
                n_fail++;
                $display("FAIL free_run i=%0d: got %h want %h (q=%0d st=%b bt=%b)",
                         i, obs_vec(), exp_vec(), q, sample_tick, bit_tick);
            end
            step();
        end
    endtask

    task automatic test_div_update();
        int guard;
        int gap;
        idle_inputs();
        guard = 0;
        while (q !== 16'd1 && guard < 20) begin step(); guard++; end
        n_tests++;
        if (q !== 16'd1) begin n_fail++; $display("FAIL div_update_wait: q=%0d want 1", q); end
        div_wr = 1'b1; div_in = 16'd6;
        step();
        div_wr = 1'b0;
        #1;
        n_tests++;
        if (div_busy !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL div_update_busy: got %h want %h", obs_vec(), exp_vec());
        end
        guard = 0;
        while (sample_tick !== 1'b1 && guard < 20) begin step(); #1; guard++; end
        n_tests++;
        if (sample_tick !== 1'b1 || q !== 16'd3 || div_cur !== 16'd4) begin
            n_fail++; $display("FAIL div_update_old_period: st=%b q=%0d div=%0d want 1 3 4",
                               sample_tick, q, div_cur);
        end
        step();
        #1;
        n_tests++;
        if (div_cur !== 16'd6 || div_busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL div_update_apply: got %h want %h", obs_vec(), exp_vec());
        end
        gap = 1;
        while (sample_tick !== 1'b1 && gap < 20) begin step(); #1; gap++; end
        n_tests++;
        if (gap !== 6 || q !== 16'd5) begin
            n_fail++; $display("FAIL div_update_new_period: got %0d want 6 (q=%0d)", gap, q);
        end
        step();
    endtask

    task automatic test_div_reject();
        rst = 1'b1; step(); rst = 1'b0;
        idle_inputs();
        div_wr = 1'b1; div_in = 16'd1;
        step();
        div_in = 16'd0;
        #1;
        n_tests++;
        if (div_err !== 1'b1 || div_cur !== 16'd4 || div_busy !== 1'b0) begin
            n_fail++; $display("FAIL div_reject_1: err=%b div=%0d busy=%b want 1 4 0",
                               div_err, div_cur, div_busy);
        end
        step();
        div_wr = 1'b0;
        #1;
        n_tests++;
        if (div_err !== 1'b1 || div_cur !== 16'd4 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL div_reject_0: got %h want %h", obs_vec(), exp_vec());
        end
        step();
        #1;
        n_tests++;
        if (div_err !== 1'b0 || div_busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL div_reject_clear: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_enable_hold();
        int guard;
        idle_inputs();
        guard = 0;
        while (q !== 16'd2 && guard < 20) begin step(); guard++; end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (q !== 16'd2 || sample_tick !== 1'b0 || bit_tick !== 1'b0 ||
                obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL enable_hold i=%0d: q=%0d st=%b want 2 0", i, q, sample_tick);
            end
            step();
        end
        en = 1'b1;
        #1;
        n_tests++;
        if (sample_tick !== 1'b0 || q !== 16'd2) begin
            n_fail++; $display("FAIL enable_resume_0: st=%b q=%0d want 0 2", sample_tick, q);
        end
        step();
        #1;
        n_tests++;
        if (sample_tick !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL enable_resume_1: got %h want %h", obs_vec(), exp_vec());
        end
        step();
    endtask

    task automatic test_sync_clr();
        int guard;
        int cnt;
        idle_inputs();
        guard = 0;
        while (!(q === 16'd0 && os_q === 2'd2) && guard < 40) begin step(); guard++; end
        div_wr = 1'b1; div_in = 16'd8;
        step();
        div_wr = 1'b0;
        sync_clr = 1'b1;
        #1;
        n_tests++;
        if (q !== 16'd1 || os_q !== 2'd2 || div_busy !== 1'b1 ||
            sample_tick !== 1'b0 || bit_tick !== 1'b0) begin
            n_fail++; $display("FAIL sync_clr_cycle: q=%0d os=%0d busy=%b st=%b want 1 2 1 0",
                               q, os_q, div_busy, sample_tick);
        end
        step();
        sync_clr = 1'b0;
        #1;
        n_tests++;
        if (q !== 16'd0 || os_q !== 2'd0 || div_cur !== 16'd8 || div_busy !== 1'b0 ||
            obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL sync_clr_after: got %h want %h", obs_vec(), exp_vec());
        end
        cnt = 0;
        while (bit_tick !== 1'b1 && cnt < 64) begin
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL sync_clr_run c=%0d: got %h want %h", cnt, obs_vec(), exp_vec());
            end
            step(); #1; cnt++;
        end
        n_tests++;
        if (cnt !== 31) begin
            n_fail++; $display("FAIL sync_clr_bit_tick: got %0d cycles want 32", cnt + 1);
        end
        step();
    endtask

    task automatic test_bypass_and_reset();
        int guard;
        rst = 1'b1; step(); rst = 1'b0;
        idle_inputs();
        guard = 0;
        while (q !== 16'd3 && guard < 20) begin step(); guard++; end
        div_wr = 1'b1; div_in = 16'd5;
        #1;
        n_tests++;
        if (sample_tick !== 1'b1 || div_busy !== 1'b0) begin
            n_fail++; $display("FAIL bypass_cycle: st=%b busy=%b want 1 0", sample_tick, div_busy);
        end
        step();
        div_wr = 1'b0;
        #1;
        n_tests++;
        if (div_cur !== 16'd5 || div_busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL bypass_apply: got %h want %h", obs_vec(), exp_vec());
        end
        div_wr = 1'b1; div_in = 16'd7;
        step();
        div_wr = 1'b0;
        #1;
        n_tests++;
        if (div_busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy_setup: busy=%b want 1", div_busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (div_cur !== 16'd4 || div_busy !== 1'b0 || q !== 16'd0 || os_q !== 2'd0 ||
            obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_while_busy: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_discard i=%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            step(); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            sync_clr = ($urandom_range(0, 39) == 0);
            div_wr   = ($urandom_range(0, 14) == 0);
            div_in   = 16'($urandom_range(0, 7));
            #1;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random i=%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            step();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_div_update();
        test_div_reject();
        test_enable_hold();
        test_sync_clr();
        test_bypass_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
